// File: rtl/aer_event_receiver_if.sv
// Bus bundle for the AER receiver: four-phase encoder handshake on one side,
// valid/ready event stream plus status toward the SNN core on the other.
interface aer_event_receiver_if #(
    parameter int ADDR_BITS  = 10,
    parameter int FIFO_DEPTH = 8
);
    localparam int LEVEL_BITS = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_BITS-1:0]  AERIN_ADDR;
    logic                  AERIN_REQ;
    logic                  AERIN_ACK;
    logic [ADDR_BITS-1:0]  EVT_ADDR;
    logic                  EVT_VALID;
    logic                  EVT_READY;
    logic [LEVEL_BITS-1:0] FIFO_LEVEL;
    logic [15:0]           DROP_CNT;

    // Environment side: encoder and core
    modport master (
        output AERIN_ADDR, AERIN_REQ, EVT_READY,
        input  AERIN_ACK, EVT_ADDR, EVT_VALID, FIFO_LEVEL, DROP_CNT
    );

    // Receiver side
    modport slave (
        input  AERIN_ADDR, AERIN_REQ, EVT_READY,
        output AERIN_ACK, EVT_ADDR, EVT_VALID, FIFO_LEVEL, DROP_CNT
    );
endinterface

// File: rtl/aer_event_receiver.sv
// AER four-phase receiver: synchronizes REQ, acknowledges one event per handshake
// into a first-word-fall-through FIFO. Optional macro AER_ADDR_FILTER_EN drops
// events whose two address MSBs are non-zero and counts them in DROP_CNT.
module aer_event_receiver #(
    parameter int ADDR_BITS  = 10,
    parameter int FIFO_DEPTH = 8
) (
    input logic               CLK,
    input logic               RST,
    aer_event_receiver_if.slave bus
);
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_BITS = PTR_BITS + 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t                state;
    state_t                state_next;
    logic                  req_meta;
    logic                  req_s;
    logic                  ack_q;
    logic                  ack_next;
    logic                  accept;
    logic                  filtered;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [LEVEL_BITS-1:0] level;
    logic [15:0]           drop_cnt;
    logic [ADDR_BITS-1:0]  mem [FIFO_DEPTH];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= bus.AERIN_REQ;
            req_s    <= req_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= ack_next;
        end
    end

    // Full is judged on the current level only, so a same-cycle pop never frees a slot
    always_comb begin
        state_next = state;
        ack_next   = ack_q;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && !full) begin
                    accept     = 1'b1;
                    ack_next   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                ack_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign full  = (level == LEVEL_BITS'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign push  = accept && !filtered;
    assign pop   = !empty && bus.EVT_READY;

`ifdef AER_ADDR_FILTER_EN
    assign filtered = (bus.AERIN_ADDR[ADDR_BITS-1 -: 2] != 2'b00);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            drop_cnt <= 16'h0000;
        end else if (accept && filtered && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign filtered = 1'b0;
    assign drop_cnt = 16'h0000;
`endif

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.AERIN_ADDR;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_BITS'(1);
                2'b01:   level <= level - LEVEL_BITS'(1);
                default: level <= level;
            endcase
        end
    end

    assign bus.AERIN_ACK  = ack_q;
    assign bus.EVT_VALID  = !empty;
    assign bus.EVT_ADDR   = empty ? '0 : mem[rd_ptr];
    assign bus.FIFO_LEVEL = level;
    assign bus.DROP_CNT   = drop_cnt;
endmodule

// File: tb/tb_aer_event_receiver.sv
// Self-checking bench for aer_event_receiver: handshake latency, backpressure,
// FIFO order and wrap, simultaneous push/pop, reset mid-handshake, optional filter.
module tb_aer_event_receiver;
    localparam int ADDR_BITS  = 10;
    localparam int FIFO_DEPTH = 8;

    typedef struct {
        logic [ADDR_BITS-1:0] addr;
        logic [3:0]           exp_level;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   pushed = 0;
    int   received = 0;
    bit   send_done = 1'b0;
    logic [ADDR_BITS-1:0] sb_q[$];
    logic [ADDR_BITS-1:0] head_exp;
    logic [ADDR_BITS-1:0] next_exp;
    vec_t vecs[8];

    always #5 clk = ~clk;

    aer_event_receiver_if #(.ADDR_BITS(ADDR_BITS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    aer_event_receiver #(.ADDR_BITS(ADDR_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input logic [ADDR_BITS-1:0] addr);
        sb_q.push_back(addr);
        pushed++;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (bus.AERIN_ACK !== lvl && n < 200) begin
            tick();
            n++;
        end
        check_output(name, 32'(bus.AERIN_ACK), 32'(lvl));
    endtask

    task automatic apply_stimulus(input logic [ADDR_BITS-1:0] addr, input bit forwarded);
        bus.AERIN_ADDR = addr;
        bus.AERIN_REQ  = 1'b1;
        if (forwarded) expect_event(addr);
        wait_ack(1'b1, "ack_rise");
        bus.AERIN_REQ = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    // Scoreboard side: a pop happens at the next rising edge whenever valid&ready here
    always @(negedge clk) begin
        if (rst && bus.EVT_VALID && bus.EVT_READY) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_pop: got 0x%0h expected no event", bus.EVT_ADDR);
            end else begin
                head_exp = sb_q.pop_front();
                check_output("pop_order", 32'(bus.EVT_ADDR), 32'(head_exp));
                received++;
            end
        end
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{10'h001, 4'd1};
        vecs[1] = '{10'h0AA, 4'd2};
        vecs[2] = '{10'h055, 4'd3};
        vecs[3] = '{10'h0FF, 4'd4};
        vecs[4] = '{10'h000, 4'd5};
        vecs[5] = '{10'h0C3, 4'd6};
        vecs[6] = '{10'h0F0, 4'd7};
        vecs[7] = '{10'h03C, 4'd8};

        bus.AERIN_ADDR = '0;
        bus.AERIN_REQ  = 1'b0;
        bus.EVT_READY  = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check_output("rst_ack",   32'(bus.AERIN_ACK),  32'd0);
        check_output("rst_valid", 32'(bus.EVT_VALID),  32'd0);
        check_output("rst_level", 32'(bus.FIFO_LEVEL), 32'd0);
        check_output("rst_drop",  32'(bus.DROP_CNT),   32'd0);
        check_output("rst_addr",  32'(bus.EVT_ADDR),   32'd0);
        rst = 1'b1;
        tick();

        // Single event with exact three-edge latency on both handshake phases
        bus.AERIN_ADDR = 10'h03A;
        bus.AERIN_REQ  = 1'b1;
        expect_event(10'h03A);
        tick();
        check_output("lat_rise_e1", 32'(bus.AERIN_ACK), 32'd0);
        tick();
        check_output("lat_rise_e2", 32'(bus.AERIN_ACK), 32'd0);
        check_output("lat_valid_e2", 32'(bus.EVT_VALID), 32'd0);
        tick();
        check_output("lat_rise_e3", 32'(bus.AERIN_ACK), 32'd1);
        check_output("single_valid", 32'(bus.EVT_VALID), 32'd1);
        check_output("single_addr",  32'(bus.EVT_ADDR),  32'h03A);
        check_output("single_level", 32'(bus.FIFO_LEVEL), 32'd1);
        bus.AERIN_REQ = 1'b0;
        tick();
        check_output("lat_fall_e1", 32'(bus.AERIN_ACK), 32'd1);
        tick();
        check_output("lat_fall_e2", 32'(bus.AERIN_ACK), 32'd1);
        tick();
        check_output("lat_fall_e3", 32'(bus.AERIN_ACK), 32'd0);
        bus.EVT_READY = 1'b1;
        tick();
        bus.EVT_READY = 1'b0;
        check_output("single_popped", 32'(bus.EVT_VALID), 32'd0);

        // Table-driven fill to full with the core stalled
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].addr, 1'b1);
            check_output("fill_level", 32'(bus.FIFO_LEVEL), 32'(vecs[i].exp_level));
            check_output("fill_head",  32'(bus.EVT_ADDR),   32'(vecs[0].addr));
        end

        // Ninth event is held off by backpressure until one pop
        bus.AERIN_ADDR = 10'h077;
        bus.AERIN_REQ  = 1'b1;
        expect_event(10'h077);
        repeat (10) tick();
        check_output("bp_no_ack", 32'(bus.AERIN_ACK),  32'd0);
        check_output("bp_level",  32'(bus.FIFO_LEVEL), 32'd8);
        bus.EVT_READY = 1'b1;
        tick();
        bus.EVT_READY = 1'b0;
        check_output("bp_pop_level", 32'(bus.FIFO_LEVEL), 32'd7);
        check_output("bp_pop_noack", 32'(bus.AERIN_ACK),  32'd0);
        tick();
        check_output("bp_ack",       32'(bus.AERIN_ACK),  32'd1);
        check_output("bp_refill",    32'(bus.FIFO_LEVEL), 32'd8);
        bus.AERIN_REQ = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");

        // Drain to level 3, then push and pop on the same edge
        bus.EVT_READY = 1'b1;
        repeat (5) tick();
        bus.EVT_READY = 1'b0;
        check_output("drain_level", 32'(bus.FIFO_LEVEL), 32'd3);
        bus.AERIN_ADDR = 10'h0AB;
        bus.AERIN_REQ  = 1'b1;
        expect_event(10'h0AB);
        tick();
        tick();
        next_exp = sb_q[1];
        bus.EVT_READY = 1'b1;
        tick();
        bus.EVT_READY = 1'b0;
        check_output("pp_ack",   32'(bus.AERIN_ACK),  32'd1);
        check_output("pp_level", 32'(bus.FIFO_LEVEL), 32'd3);
        check_output("pp_head",  32'(bus.EVT_ADDR),   32'(next_exp));
        bus.AERIN_REQ = 1'b0;
        wait_ack(1'b0, "pp_ack_fall");

        // Twenty events through the wrapping FIFO with a random-ready core
        send_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    apply_stimulus(ADDR_BITS'(i), 1'b1);
                end
                send_done = 1'b1;
            end
            begin
                while (!send_done) begin
                    bus.EVT_READY = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.EVT_READY = 1'b1;
        for (int n = 0; n < 100 && bus.FIFO_LEVEL != 0; n++) tick();
        bus.EVT_READY = 1'b0;
        check_output("wrap_empty",     32'(bus.FIFO_LEVEL), 32'd0);
        check_output("wrap_delivered", 32'(received),       32'(pushed));

        // Reset while in ACK with two events buffered
        apply_stimulus(10'h011, 1'b1);
        apply_stimulus(10'h022, 1'b1);
        check_output("pre_rst_level", 32'(bus.FIFO_LEVEL), 32'd2);
        bus.AERIN_ADDR = 10'h033;
        bus.AERIN_REQ  = 1'b1;
        wait_ack(1'b1, "pre_rst_ack");
        rst = 1'b0;
        bus.AERIN_REQ = 1'b0;
        sb_q.delete();
        tick();
        check_output("mid_rst_ack",   32'(bus.AERIN_ACK),  32'd0);
        check_output("mid_rst_valid", 32'(bus.EVT_VALID),  32'd0);
        check_output("mid_rst_level", 32'(bus.FIFO_LEVEL), 32'd0);
        rst = 1'b1;
        repeat (4) tick();
        check_output("post_rst_ack",   32'(bus.AERIN_ACK), 32'd0);
        check_output("post_rst_valid", 32'(bus.EVT_VALID), 32'd0);

`ifdef AER_ADDR_FILTER_EN
        apply_stimulus(10'h100, 1'b0);
        repeat (2) tick();
        check_output("filt_valid", 32'(bus.EVT_VALID), 32'd0);
        check_output("filt_drop",  32'(bus.DROP_CNT),  32'd1);
        apply_stimulus(10'h0FF, 1'b1);
        check_output("filt_pass_valid", 32'(bus.EVT_VALID), 32'd1);
        check_output("filt_pass_addr",  32'(bus.EVT_ADDR),  32'h0FF);
        check_output("filt_pass_drop",  32'(bus.DROP_CNT),  32'd1);
        bus.EVT_READY = 1'b1;
        tick();
        bus.EVT_READY = 1'b0;
`else
        apply_stimulus(10'h100, 1'b1);
        check_output("nofilt_valid", 32'(bus.EVT_VALID), 32'd1);
        check_output("nofilt_addr",  32'(bus.EVT_ADDR),  32'h100);
        check_output("nofilt_drop",  32'(bus.DROP_CNT),  32'd0);
        bus.EVT_READY = 1'b1;
        tick();
        bus.EVT_READY = 1'b0;
`endif
        tick();
        check_output("final_empty", 32'(bus.FIFO_LEVEL), 32'd0);
        check_output("final_sb",    32'(sb_q.size()),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
